// File: rtl/tdl_mc_if.sv
// Bus bundle between the sample source and the channel-interleaved tapped delay line.
// The master side drives samples and flush; the slave side returns per-channel tap vectors.
interface tdl_mc_if #(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8,
    parameter int CHANNELS   = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                         VIN;
    logic signed [DATA_WIDTH-1:0] DIN;
    logic                         FLUSH;
    logic                         VOUT;
    logic [CW-1:0]                CH_OUT;
    logic signed [DATA_WIDTH-1:0] TP [0:TAPS-1];
    logic                         PRIMED;

    modport master (
        output VIN, DIN, FLUSH,
        input  VOUT, CH_OUT, TP, PRIMED
    );

    modport slave (
        input  VIN, DIN, FLUSH,
        output VOUT, CH_OUT, TP, PRIMED
    );
endinterface

// File: rtl/tdl_mc.sv
// Channel-interleaved tapped delay line: one TAPS-deep line per channel, fed round-robin,
// presenting the updated line of the current channel one cycle after each accepted sample.
module tdl_mc #(
    parameter int DATA_WIDTH = 13,
    parameter int TAPS       = 8,
    parameter int CHANNELS   = 4
) (
    input  logic    CLK,
    input  logic    RST,
    tdl_mc_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = $clog2(TAPS + 1);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic [FW-1:0]                fill_t;
    typedef logic [CW-1:0]                chan_t;

    localparam fill_t FILL_FULL = fill_t'(TAPS);
    localparam chan_t CH_LAST   = chan_t'(CHANNELS - 1);

    sample_t line_q [CHANNELS][TAPS];
    sample_t line_d [CHANNELS][TAPS];
    fill_t   fill_q [CHANNELS];
    fill_t   fill_d [CHANNELS];
    chan_t   ptr_q, ptr_d;

    sample_t tp_q [TAPS];
    sample_t tp_d [TAPS];
    chan_t   ch_q, ch_d;
    logic    vout_q, vout_d;
    logic    primed_q, primed_d;

    fill_t   fill_inc;

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        line_d   = line_q;
        fill_d   = fill_q;
        ptr_d    = ptr_q;
        tp_d     = tp_q;
        ch_d     = ch_q;
        vout_d   = 1'b0;
        primed_d = primed_q;
        fill_inc = (fill_q[ptr_q] == FILL_FULL) ? FILL_FULL : fill_q[ptr_q] + fill_t'(1);

        if (bus.FLUSH) begin
            // Flush wins over a simultaneous sample, which is dropped without advancing ptr.
            line_d   = '{default: '0};
            fill_d   = '{default: '0};
            ptr_d    = '0;
            tp_d     = '{default: '0};
            ch_d     = '0;
            primed_d = 1'b0;
        end else if (bus.VIN) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                line_d[ptr_q][i] = line_q[ptr_q][i-1];
            end
            line_d[ptr_q][0] = bus.DIN;
            fill_d[ptr_q]    = fill_inc;
            ptr_d            = (ptr_q == CH_LAST) ? '0 : ptr_q + chan_t'(1);
            tp_d             = line_d[ptr_q];
            ch_d             = ptr_q;
            vout_d           = 1'b1;
            primed_d         = (fill_inc == FILL_FULL);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the line storage is reset (not left uninitialised) because unfilled taps must read as zero.
            line_q   <= '{default: '0};
            fill_q   <= '{default: '0};
            ptr_q    <= '0;
            tp_q     <= '{default: '0};
            ch_q     <= '0;
            vout_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            line_q   <= line_d;
            fill_q   <= fill_d;
            ptr_q    <= ptr_d;
            tp_q     <= tp_d;
            ch_q     <= ch_d;
            vout_q   <= vout_d;
            primed_q <= primed_d;
        end
    end

    assign bus.VOUT   = vout_q;
    assign bus.CH_OUT = ch_q;
    assign bus.TP     = tp_q;
    assign bus.PRIMED = primed_q;

endmodule
